// File: rtl/coherence_bus_arbiter_pkg.sv
// Purpose : shared types for the dual-core coherence bus arbiter.
// Latency : n/a (types and a pure helper function only).
// Backpr. : n/a.
package coherence_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    NONE     = 2'b00,
    BUS_RD   = 2'b01,
    BUS_RDX  = 2'b10,
    BUS_UPGR = 2'b11
  } bus_op_t;

  typedef enum logic [1:0] {
    DSEL_NONE  = 2'b00,
    DSEL_MEM   = 2'b01,
    DSEL_OTHER = 2'b10
  } datasel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SNOOP = 2'b01,
    RESP  = 2'b10,
    HOLD  = 2'b11
  } arb_state_t;

  // Invalidate outranks write miss, which outranks read miss.
  function automatic bus_op_t op_select(input logic rd, input logic wr, input logic inv);
    if (inv)      return BUS_UPGR;
    else if (wr)  return BUS_RDX;
    else if (rd)  return BUS_RD;
    else          return NONE;
  endfunction

endpackage

// File: rtl/coherence_bus_arbiter_rr_arbiter2.sv
// Purpose : 2-way round-robin winner select plus the last_grant history bit.
// Latency : winner is combinational from req; last_grant updates on the edge after update.
// Backpr. : none; the loser simply keeps requesting until it wins.
// Ports   : clk, rst, req[1:0], update/update_id (commit a finished grant),
//           any_req, winner (CPU id to grant).
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       update_id,
  output logic       any_req,
  output logic       winner
);

  logic last_grant;

  always_comb begin
    any_req = |req;
    winner  = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_grant;  // tie goes to whoever did not win last
      default: winner = 1'b0;
    endcase
  end

  // Reset to 1 so that CPU0 takes the first tie.
  always_ff @(posedge clk) begin
    if (rst)         last_grant <= 1'b1;
    else if (update) last_grant <= update_id;
  end

endmodule

// File: rtl/coherence_bus_arbiter.sv
// Purpose : arbitrates read-miss / write-miss / invalidate from two CPUs, snoops the other
//           CPU, and reports the data source (other CPU or memory) to the requester.
// Latency : grant 1 cycle after request; snoop 1..SNOOP_WAIT cycles; RESP 1 cycle; HOLD until req drops.
// Backpr. : one transaction in flight; the other CPU's request waits (never dropped) until HOLD ends.
// Ports   : read_miss/write_miss/invalidate[2], BICO0/1 addresses, cpu_search_found[2] and
//           send_other_proc_data0/1 snoop replies in; grant, cpu_dmem_permission, cpu_search,
//           BOCI {op,addr}, cpu_datasel0/1, invalidate_from_other_cpu, other_proc_data0/1 out.
module coherence_bus_arbiter
  import coherence_bus_arbiter_pkg::*;
#(
  parameter int SNOOP_WAIT = 4,
  parameter int ADDR_W     = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        read_miss,
  input  logic [1:0]        write_miss,
  input  logic [1:0]        invalidate,
  input  logic [ADDR_W-1:0] BICO0,
  input  logic [ADDR_W-1:0] BICO1,
  input  logic [1:0]        cpu_search_found,
  input  logic [15:0]       send_other_proc_data0,
  input  logic [15:0]       send_other_proc_data1,
  output logic [1:0]        grant,
  output logic [1:0]        cpu_dmem_permission,
  output logic [1:0]        cpu_search,
  output logic [ADDR_W+1:0] BOCI,
  output logic [1:0]        cpu_datasel0,
  output logic [1:0]        cpu_datasel1,
  output logic [1:0]        invalidate_from_other_cpu,
  output logic [15:0]       other_proc_data0,
  output logic [15:0]       other_proc_data1
);

  localparam logic [3:0] WAIT_LAST = 4'(SNOOP_WAIT - 1);

  arb_state_t state;
  bus_op_t    op;
  logic       w;          // granted CPU id
  logic [3:0] counter;

  logic [1:0]        req;
  logic              any_req;
  logic              win;
  logic              release_now;
  bus_op_t           sel_op;
  logic [ADDR_W-1:0] sel_addr;
  logic              found_other;
  logic [15:0]       other_data;
  datasel_t          resp_dsel;

  assign req = read_miss | write_miss | invalidate;

  // HOLD ends when the granted CPU drops all of its request flags.
  assign release_now = (state == HOLD) && !req[w];

  rr_arbiter2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .update    (release_now),
    .update_id (w),
    .any_req   (any_req),
    .winner    (win)
  );

  always_comb begin
    sel_op      = op_select(read_miss[win], write_miss[win], invalidate[win]);
    sel_addr    = win ? BICO1 : BICO0;
    // Only the non-requesting CPU's snoop reply counts.
    found_other = w ? cpu_search_found[0] : cpu_search_found[1];
    other_data  = w ? send_other_proc_data0 : send_other_proc_data1;
    if (op == BUS_UPGR)  resp_dsel = DSEL_NONE;
    else if (found_other) resp_dsel = DSEL_OTHER;
    else                  resp_dsel = DSEL_MEM;
  end

  assign cpu_dmem_permission = grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      state                     <= IDLE;
      op                        <= NONE;
      w                         <= 1'b0;
      counter                   <= '0;
      grant                     <= '0;
      cpu_search                <= '0;
      BOCI                      <= '0;
      cpu_datasel0              <= DSEL_NONE;
      cpu_datasel1              <= DSEL_NONE;
      invalidate_from_other_cpu <= '0;
      other_proc_data0          <= '0;
      other_proc_data1          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            w          <= win;
            op         <= sel_op;
            grant      <= win ? 2'b10 : 2'b01;
            cpu_search <= win ? 2'b01 : 2'b10;
            BOCI       <= {sel_op, sel_addr};
            counter    <= '0;
            state      <= SNOOP;
          end
        end

        SNOOP: begin
          counter <= counter + 4'd1;
          if (found_other || counter == WAIT_LAST) begin
            cpu_search <= '0;
            if (w) cpu_datasel1 <= resp_dsel;
            else   cpu_datasel0 <= resp_dsel;
            // Forward the snooped block only when the other CPU supplied it.
            if (found_other && op != BUS_UPGR) begin
              if (w) other_proc_data1 <= other_data;
              else   other_proc_data0 <= other_data;
            end
            // RDX and UPGR both take exclusive ownership: kill the other copy.
            if (op != BUS_RD)
              invalidate_from_other_cpu <= w ? 2'b01 : 2'b10;
            state <= RESP;
          end
        end

        RESP: begin
          invalidate_from_other_cpu <= '0;
          state                     <= HOLD;
        end

        HOLD: begin
          if (release_now) begin
            grant            <= '0;
            BOCI             <= '0;
            cpu_datasel0     <= DSEL_NONE;
            cpu_datasel1     <= DSEL_NONE;
            other_proc_data0 <= '0;
            other_proc_data1 <= '0;
            state            <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
module tb_coherence_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  read_miss, write_miss, invalidate, cpu_search_found;
  logic [10:0] BICO0, BICO1;
  logic [15:0] send_other_proc_data0, send_other_proc_data1;
  logic [1:0]  grant, cpu_dmem_permission, cpu_search, cpu_datasel0, cpu_datasel1;
  logic [1:0]  invalidate_from_other_cpu;
  logic [12:0] BOCI;
  logic [15:0] other_proc_data0, other_proc_data1;

  coherence_bus_arbiter #(.SNOOP_WAIT(4), .ADDR_W(11)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .read_miss                 (read_miss),
    .write_miss                (write_miss),
    .invalidate                (invalidate),
    .BICO0                     (BICO0),
    .BICO1                     (BICO1),
    .cpu_search_found          (cpu_search_found),
    .send_other_proc_data0     (send_other_proc_data0),
    .send_other_proc_data1     (send_other_proc_data1),
    .grant                     (grant),
    .cpu_dmem_permission       (cpu_dmem_permission),
    .cpu_search                (cpu_search),
    .BOCI                      (BOCI),
    .cpu_datasel0              (cpu_datasel0),
    .cpu_datasel1              (cpu_datasel1),
    .invalidate_from_other_cpu (invalidate_from_other_cpu),
    .other_proc_data0          (other_proc_data0),
    .other_proc_data1          (other_proc_data1)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        r;
    logic [1:0]  rm, wm, inv, fnd;
    logic [10:0] b0, b1;
    logic [1:0]  eg, es;
    logic [12:0] eb;
    logic [1:0]  ed0, ed1, ei;
    logic [15:0] eo0, eo1;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input string nm, input logic r, input logic [1:0] rm, wm, inv, fnd,
                     input logic [10:0] b0, b1, input logic [1:0] eg, es, input logic [12:0] eb,
                     input logic [1:0] ed0, ed1, ei, input logic [15:0] eo0, eo1);
    vec_t v;
    v.name = nm; v.r = r; v.rm = rm; v.wm = wm; v.inv = inv; v.fnd = fnd;
    v.b0 = b0; v.b1 = b1; v.eg = eg; v.es = es; v.eb = eb;
    v.ed0 = ed0; v.ed1 = ed1; v.ei = ei; v.eo0 = eo0; v.eo1 = eo1;
    vq.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {7'd0, grant, cpu_dmem_permission, cpu_search, BOCI, cpu_datasel0, cpu_datasel1,
            invalidate_from_other_cpu, other_proc_data0, other_proc_data1};
  endfunction

  task automatic wait_grant(input string nm, input logic [1:0] g);
    int n = 0;
    while (grant !== g && n < 10) begin
      step();
      n++;
    end
    chk(nm, {62'd0, grant}, {62'd0, g});
  endtask

  initial begin
    rst = 1'b1; read_miss = '0; write_miss = '0; invalidate = '0; cpu_search_found = '0;
    BICO0 = '0; BICO1 = '0;
    send_other_proc_data0 = 16'hCAFE; send_other_proc_data1 = 16'hBEEF;

    // Test 1: CPU0 read miss, CPU1 hits on its second snoop cycle. BICO0 moves after grant.
    add("t1_reset",  1, 2'b00,0,0,2'b00, 11'h05A,0, 2'b00,2'b00,13'h0000, 2'b00,2'b00,2'b00, 16'h0,0);
    add("t1_grant",  0, 2'b01,0,0,2'b00, 11'h05A,0, 2'b01,2'b10,13'h085A, 2'b00,2'b00,2'b00, 16'h0,0);
    add("t1_snoop",  0, 2'b01,0,0,2'b00, 11'h3FF,0, 2'b01,2'b10,13'h085A, 2'b00,2'b00,2'b00, 16'h0,0);
    add("t1_resp",   0, 2'b01,0,0,2'b10, 11'h3FF,0, 2'b01,2'b00,13'h085A, 2'b10,2'b00,2'b00, 16'hBEEF,0);
    add("t1_hold",   0, 2'b01,0,0,2'b00, 11'h3FF,0, 2'b01,2'b00,13'h085A, 2'b10,2'b00,2'b00, 16'hBEEF,0);
    add("t1_release",0, 2'b00,0,0,2'b00, 11'h3FF,0, 2'b00,2'b00,13'h0000, 2'b00,2'b00,2'b00, 16'h0,0);
    // Test 2: CPU1 write miss, no hit, times out after 4 snoop cycles. Invalidate raised
    // after grant must not turn the latched RDX into UPGR.
    add("t2_grant",  0, 2'b00,2'b10,2'b00,2'b00, 0,11'h123, 2'b10,2'b01,13'h1123, 2'b00,2'b00,2'b00, 16'h0,0);
    for (int i = 0; i < 3; i++)
      add("t2_snoop",0, 2'b00,2'b10,2'b10,2'b00, 0,11'h123, 2'b10,2'b01,13'h1123, 2'b00,2'b00,2'b00, 16'h0,0);
    add("t2_resp",   0, 2'b00,2'b10,2'b10,2'b00, 0,11'h123, 2'b10,2'b00,13'h1123, 2'b00,2'b01,2'b01, 16'h0,0);
    add("t2_hold",   0, 2'b00,2'b10,2'b10,2'b00, 0,11'h123, 2'b10,2'b00,13'h1123, 2'b00,2'b01,2'b00, 16'h0,0);
    add("t2_release",0, 2'b00,2'b00,2'b00,2'b00, 0,11'h123, 2'b00,2'b00,13'h0000, 2'b00,2'b00,2'b00, 16'h0,0);
    // Test 3: simultaneous requests straight after reset; CPU0 first, then one idle cycle, CPU1.
    add("t3_reset",  1, 2'b00,0,0,2'b00, 11'h010,11'h020, 2'b00,2'b00,13'h0000, 2'b00,2'b00,2'b00, 16'h0,0);
    add("t3_grant0", 0, 2'b11,0,0,2'b00, 11'h010,11'h020, 2'b01,2'b10,13'h0810, 2'b00,2'b00,2'b00, 16'h0,0);
    for (int i = 0; i < 3; i++)
      add("t3_snoop0",0,2'b11,0,0,2'b00, 11'h010,11'h020, 2'b01,2'b10,13'h0810, 2'b00,2'b00,2'b00, 16'h0,0);
    add("t3_resp0",  0, 2'b11,0,0,2'b00, 11'h010,11'h020, 2'b01,2'b00,13'h0810, 2'b01,2'b00,2'b00, 16'h0,0);
    add("t3_hold0",  0, 2'b11,0,0,2'b00, 11'h010,11'h020, 2'b01,2'b00,13'h0810, 2'b01,2'b00,2'b00, 16'h0,0);
    add("t3_idle",   0, 2'b10,0,0,2'b00, 11'h010,11'h020, 2'b00,2'b00,13'h0000, 2'b00,2'b00,2'b00, 16'h0,0);
    add("t3_grant1", 0, 2'b10,0,0,2'b00, 11'h010,11'h020, 2'b10,2'b01,13'h0820, 2'b00,2'b00,2'b00, 16'h0,0);
    for (int i = 0; i < 3; i++)
      add("t3_snoop1",0,2'b10,0,0,2'b00, 11'h010,11'h020, 2'b10,2'b01,13'h0820, 2'b00,2'b00,2'b00, 16'h0,0);
    add("t3_resp1",  0, 2'b10,0,0,2'b00, 11'h010,11'h020, 2'b10,2'b00,13'h0820, 2'b00,2'b01,2'b00, 16'h0,0);
    add("t3_hold1",  0, 2'b00,0,0,2'b00, 11'h010,11'h020, 2'b10,2'b00,13'h0820, 2'b00,2'b01,2'b00, 16'h0,0);
    add("t3_release",0, 2'b00,0,0,2'b00, 11'h010,11'h020, 2'b00,2'b00,13'h0000, 2'b00,2'b00,2'b00, 16'h0,0);

    foreach (vq[i]) begin
      rst = vq[i].r; read_miss = vq[i].rm; write_miss = vq[i].wm; invalidate = vq[i].inv;
      cpu_search_found = vq[i].fnd; BICO0 = vq[i].b0; BICO1 = vq[i].b1;
      step();
      chk(vq[i].name, outs(),
          {7'd0, vq[i].eg, vq[i].eg, vq[i].es, vq[i].eb, vq[i].ed0, vq[i].ed1, vq[i].ei,
           vq[i].eo0, vq[i].eo1});
    end

    // Test 4: CPU0 invalidate at the top address; exactly one invalidate pulse to CPU1.
    begin
      int pulses = 0, bad_inv0 = 0, bad_ds0 = 0;
      invalidate = 2'b01; BICO0 = 11'h7FF;
      step();
      wait_grant("t4_grant", 2'b01);
      chk("t4_boci", {51'd0, BOCI}, {51'd0, 13'h1FFF});
      for (int i = 0; i < 8; i++) begin
        step();
        if (invalidate_from_other_cpu[1]) pulses++;
        if (invalidate_from_other_cpu[0]) bad_inv0++;
        if (cpu_datasel0 != 2'b00) bad_ds0++;
      end
      chk("t4_inv1_pulses", 64'(pulses), 64'd1);
      chk("t4_inv0_never", 64'(bad_inv0), 64'd0);
      chk("t4_datasel0_zero", 64'(bad_ds0), 64'd0);
      invalidate = 2'b00;
      step(); step();
      chk("t4_release", {62'd0, grant}, 64'd0);
    end

    // Test 5: reset during SNOOP clears everything and restores CPU0 tie priority
    // (CPU0 won last, so without the reset CPU1 would take the tie).
    read_miss = 2'b10; BICO1 = 11'h0AA;
    step();
    wait_grant("t5_grant", 2'b10);
    step();
    chk("t5_in_snoop", {62'd0, cpu_search}, {62'd0, 2'b01});
    rst = 1'b1;
    step();
    chk("t5_reset_outs", outs(), 64'd0);
    rst = 1'b0; read_miss = 2'b11;
    step();
    chk("t5_rearb_cpu0", {62'd0, grant}, {62'd0, 2'b01});
    read_miss = 2'b00; rst = 1'b1;
    step();
    rst = 1'b0;

    // Test 6: CPU1 reports found on its own line while it is the requester: ignored.
    begin
      int lat = 0;
      read_miss = 2'b10; cpu_search_found = 2'b10;
      step();
      wait_grant("t6_grant", 2'b10);
      while (cpu_datasel1 == 2'b00 && lat < 20) begin
        step();
        lat++;
      end
      chk("t6_timeout_cycles", 64'(lat), 64'd4);
      chk("t6_datasel1_mem", {62'd0, cpu_datasel1}, {62'd0, 2'b01});
      chk("t6_no_forward", {48'd0, other_proc_data1}, 64'd0);
      read_miss = 2'b00; cpu_search_found = 2'b00;
      step(); step(); step();
      chk("t6_release", {62'd0, grant}, 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
